// File: rtl/next_kbd_responder_if.sv
// Key/mouse event handshake between an event source and the keyboard responder.
interface next_kbd_responder_if;
  logic        key_valid;
  logic [15:0] key_data;
  logic        key_ready;
  logic        mouse_valid;
  logic [15:0] mouse_data;
  logic        mouse_ready;

  // Event source side
  modport master (
    output key_valid,
    output key_data,
    output mouse_valid,
    output mouse_data,
    input  key_ready,
    input  mouse_ready
  );

  // Responder side
  modport slave (
    input  key_valid,
    input  key_data,
    input  mouse_valid,
    input  mouse_data,
    output key_ready,
    output mouse_ready
  );
endinterface

// File: rtl/next_kbd_responder.sv
// Device end of the NeXT keyboard serial link: decodes host reset/query frames and
// answers queries with 21-bit ready or data frames sourced from one-deep key/mouse
// holding registers.
module next_kbd_responder #(
  parameter int unsigned BIT_CLKS      = 264,
  parameter int unsigned HALF_BIT      = 131,
  parameter int unsigned RESP_GAP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 from_host,
  output logic                 to_host,
  next_kbd_responder_if.slave  evt,
  output logic                 configured,
  output logic                 host_reset_seen,
  output logic                 frame_error
);

  localparam int unsigned GapCycles = RESP_GAP_BITS * BIT_CLKS;
  localparam int unsigned GapW      = $clog2(GapCycles + 1);

  localparam logic [8:0]      BitLast  = 9'(BIT_CLKS - 1);
  localparam logic [8:0]      HalfLast = 9'(HALF_BIT - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GapCycles - 1);

  // Received bits are stored with the first bit in h[0].
  localparam logic [7:0]  KbdQuery   = 8'h10;
  localparam logic [7:0]  MouseQuery = 8'h11;
  localparam logic [7:0]  ResetHead  = 8'hEF;
  localparam logic [20:0] ResetFrame = 21'h0007EF;
  localparam logic [20:0] ReadyFrame = 21'h100600;

  typedef enum logic [2:0] {
    StIdle,
    StRxStart,
    StRxBits,
    StGap,
    StTxStart,
    StTxBits,
    StRecover
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      sync_q;
  logic            line_prev_q;
  logic            line;
  logic            line_fall;

  logic [8:0]      cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [20:0]     h_q, h_d;
  logic [20:0]     h_bit;
  logic            is_mouse_q, is_mouse_d;
  logic [20:0]     frame_q, frame_d;
  logic            configured_q, configured_d;
  logic            rst_pulse_q, rst_pulse_d;
  logic            err_pulse_q, err_pulse_d;
  logic            take_key, take_mouse;

  logic            key_full_q, key_full_d;
  logic [15:0]     key_data_q, key_data_d;
  logic            mouse_full_q, mouse_full_d;
  logic [15:0]     mouse_data_q, mouse_data_d;

  assign line      = sync_q[1];
  assign line_fall = line_prev_q & ~line;

  // Data frame layout: 0, lo[7:0], 0, 1, 0, hi[7:0], 0 (sent from bit 0 upward).
  function automatic logic [20:0] data_frame(input logic [15:0] d);
    return {1'b0, d[15:8], 3'b010, d[7:0], 1'b0};
  endfunction

  // Two-flop synchroniser plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], from_host};
      line_prev_q <= line;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      h_q          <= '0;
      is_mouse_q   <= 1'b0;
      frame_q      <= '0;
      configured_q <= 1'b0;
      rst_pulse_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      h_q          <= h_d;
      is_mouse_q   <= is_mouse_d;
      frame_q      <= frame_d;
      configured_q <= configured_d;
      rst_pulse_q  <= rst_pulse_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  // Next-state logic: receive, decode, gap timing, transmit and recovery.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    h_d          = h_q;
    is_mouse_d   = is_mouse_q;
    frame_d      = frame_q;
    configured_d = configured_q;
    rst_pulse_d  = 1'b0;
    err_pulse_d  = 1'b0;
    take_key     = 1'b0;
    take_mouse   = 1'b0;
    h_bit        = h_q;
    h_bit[idx_q] = line;

    unique case (state_q)
      StIdle: begin
        if (line_fall) begin
          state_d = StRxStart;
          cnt_d   = '0;
        end
      end

      StRxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          h_d     = '0;
          // A line already back high at mid start bit was only a glitch.
          state_d = line ? StIdle : StRxBits;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StRxBits: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          h_d   = h_bit;
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd7) begin
            if (h_bit[7:0] == KbdQuery || h_bit[7:0] == MouseQuery) begin
              is_mouse_d = h_bit[0];
              if (configured_q) begin
                state_d = StGap;
                gap_d   = '0;
              end else begin
                state_d = StRecover;
              end
            end else if (h_bit[7:0] != ResetHead) begin
              err_pulse_d = 1'b1;
              state_d     = StRecover;
            end
          end else if (idx_q == 5'd20) begin
            if (h_bit == ResetFrame) begin
              rst_pulse_d  = 1'b1;
              configured_d = 1'b1;
            end else begin
              err_pulse_d = 1'b1;
            end
            state_d = StRecover;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StGap: begin
        if (line_fall) begin
          // Host started a new frame: drop the response, keep held events.
          state_d = StRxStart;
          cnt_d   = '0;
        end else if (gap_q == GapLast) begin
          state_d = StTxStart;
          cnt_d   = '0;
          if (is_mouse_q) begin
            take_mouse = mouse_full_q;
            frame_d    = mouse_full_q ? data_frame(mouse_data_q) : ReadyFrame;
          end else begin
            take_key = key_full_q;
            frame_d  = key_full_q ? data_frame(key_data_q) : ReadyFrame;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      StTxStart: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StTxBits;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StTxBits: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (idx_q == 5'd20) begin
            state_d = StRecover;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StRecover: begin
        // Require one full bit time of idle-high before listening again.
        if (!line) begin
          cnt_d = '0;
        end else if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register next state: empty first, then capture a handshake.
  always_comb begin
    key_full_d   = key_full_q;
    key_data_d   = key_data_q;
    mouse_full_d = mouse_full_q;
    mouse_data_d = mouse_data_q;
    if (take_key) begin
      key_full_d = 1'b0;
    end
    if (evt.key_valid && !key_full_q) begin
      key_full_d = 1'b1;
      key_data_d = evt.key_data;
    end
    if (take_mouse) begin
      mouse_full_d = 1'b0;
    end
    if (evt.mouse_valid && !mouse_full_q) begin
      mouse_full_d = 1'b1;
      mouse_data_d = evt.mouse_data;
    end
  end

  // Key and mouse holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_full_q   <= 1'b0;
      key_data_q   <= '0;
      mouse_full_q <= 1'b0;
      mouse_data_q <= '0;
    end else begin
      key_full_q   <= key_full_d;
      key_data_q   <= key_data_d;
      mouse_full_q <= mouse_full_d;
      mouse_data_q <= mouse_data_d;
    end
  end

  // Outputs: serial line driven straight from state so reset forces it high at once.
  always_comb begin
    unique case (state_q)
      StTxStart: to_host = 1'b0;
      StTxBits:  to_host = frame_q[idx_q];
      default:   to_host = 1'b1;
    endcase
    evt.key_ready   = ~key_full_q;
    evt.mouse_ready = ~mouse_full_q;
    configured      = configured_q;
    host_reset_seen = rst_pulse_q;
    frame_error     = err_pulse_q;
  end

endmodule

// File: tb/tb_next_kbd_responder.sv
// Self-checking bench for next_kbd_responder: directed and random host frames, a
// frame-level reference model feeding a scoreboard, and a line monitor that decodes
// every to_host response. Bit timing is scaled down to keep the run short.
module tb_next_kbd_responder;

  localparam int BIT  = 40;
  localparam int HALF = 19;
  localparam int GAP  = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic from_host;
  logic to_host;
  logic configured;
  logic host_reset_seen;
  logic frame_error;

  next_kbd_responder_if bus ();

  next_kbd_responder #(
    .BIT_CLKS      (BIT),
    .HALF_BIT      (HALF),
    .RESP_GAP_BITS (GAP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .from_host       (from_host),
    .to_host         (to_host),
    .evt             (bus),
    .configured      (configured),
    .host_reset_seen (host_reset_seen),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_mid = 0;
  int n_rst_seen = 0;
  int n_err_seen = 0;

  logic [20:0] exp_q[$];

  // Reference model state
  bit          m_cfg;
  bit          m_kfull, m_mfull;
  logic [15:0] m_kdata, m_mdata;
  int          m_rst_cnt, m_err_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (host_reset_seen === 1'b1) n_rst_seen++;
    if (frame_error === 1'b1) n_err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected response: ready frame has bits 9, 10, 20 set; data frame carries
  // the low byte at bit 1 and the high byte at bit 12 with a marker at bit 10.
  function automatic logic [20:0] exp_frame(input bit full, input logic [15:0] d);
    int v;
    if (!full) v = (1 << 9) + (1 << 10) + (1 << 20);
    else v = (int'(d[7:0]) << 1) + (1 << 10) + (int'(d[15:8]) << 12);
    return v[20:0];
  endfunction

  // Monitor: decode each response on to_host and score it against the queue.
  initial begin : monitor
    logic [20:0] got;
    bit aborted;
    int lat;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && to_host === 1'b0) begin
        aborted = 1'b0;
        lat = cyc - last_mid;
        repeat (BIT / 2) begin
          @(negedge clk);
          if (reset_n !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) check("start_bit", {31'd0, to_host}, 32'd0);
        for (int i = 0; i < 21; i++) begin
          repeat (BIT) begin
            @(negedge clk);
            if (reset_n !== 1'b1) aborted = 1'b1;
          end
          got[i] = to_host;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_response: got frame %h, expected no response", got);
          end else begin
            check("resp_frame", {11'd0, got}, {11'd0, exp_q.pop_front()});
            check("resp_latency_in_window",
                  {31'd0, (lat >= GAP * BIT - 4 && lat <= GAP * BIT + 8)}, 32'd1);
          end
        end
        for (int k = 0; k < 2 * BIT && to_host !== 1'b1; k++) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got cycle limit reached, expected run to finish");
    $fatal(1, "bench timeout");
  end

  // Host frame: start bit then n bits, first bit h[0], each BIT cycles.
  task automatic send_bits(input logic [20:0] h, input int n);
    @(posedge clk);
    #1 from_host = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #1 from_host = h[i];
      if (i == n - 1) last_mid = cyc + BIT / 2;
      repeat (BIT) @(posedge clk);
    end
    #1 from_host = 1'b1;
  endtask

  task automatic check_ready();
    @(negedge clk);
    check("key_ready", {31'd0, bus.key_ready}, {31'd0, !m_kfull});
    check("mouse_ready", {31'd0, bus.mouse_ready}, {31'd0, !m_mfull});
  endtask

  task automatic offer(input bit mouse, input logic [15:0] d);
    @(posedge clk);
    #1;
    if (mouse) begin
      bus.mouse_valid = 1'b1;
      bus.mouse_data  = d;
    end else begin
      bus.key_valid = 1'b1;
      bus.key_data  = d;
    end
    @(posedge clk);
    #1;
    bus.mouse_valid = 1'b0;
    bus.key_valid   = 1'b0;
    if (mouse) begin
      m_mfull = 1'b1;
      m_mdata = d;
    end else begin
      m_kfull = 1'b1;
      m_kdata = d;
    end
  endtask

  task automatic query(input bit mouse);
    logic [20:0] h;
    h = mouse ? 21'h11 : 21'h10;
    if (m_cfg) begin
      if (mouse) begin
        exp_q.push_back(exp_frame(m_mfull, m_mdata));
        m_mfull = 1'b0;
      end else begin
        exp_q.push_back(exp_frame(m_kfull, m_kdata));
        m_kfull = 1'b0;
      end
      send_bits(h, 8);
      repeat ((GAP + 22 + 3) * BIT) @(posedge clk);
      check("resp_drained", exp_q.size(), 32'd0);
    end else begin
      send_bits(h, 8);
      repeat (3 * BIT) @(posedge clk);
    end
    check_ready();
  endtask

  task automatic bad_frame(input logic [20:0] h, input int n);
    m_err_cnt++;
    send_bits(h, n);
    repeat (3 * BIT) @(posedge clk);
    check("err_pulses", n_err_seen, m_err_cnt);
  endtask

  initial begin : stim
    logic [7:0] g;
    int r;
    reset_n         = 1'b0;
    from_host       = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_data    = '0;
    bus.mouse_valid = 1'b0;
    bus.mouse_data  = '0;
    m_cfg = 0; m_kfull = 0; m_mfull = 0; m_kdata = '0; m_mdata = '0;
    m_rst_cnt = 0; m_err_cnt = 0;

    #23;
    check("rst_to_host", {31'd0, to_host}, 32'd1);
    check("rst_key_ready", {31'd0, bus.key_ready}, 32'd1);
    check("rst_mouse_ready", {31'd0, bus.mouse_ready}, 32'd1);
    check("rst_configured", {31'd0, configured}, 32'd0);
    check("rst_host_reset_seen", {31'd0, host_reset_seen}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Unconfigured query: decoded but silent, no error
    query(1'b0);
    check("err_pulses_unconfigured", n_err_seen, m_err_cnt);

    // Short glitch on the host line is ignored
    @(posedge clk);
    #1 from_host = 1'b0;
    repeat (5) @(posedge clk);
    #1 from_host = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    check("err_pulses_glitch", n_err_seen, m_err_cnt);

    // Reset frame
    send_bits(21'h0007EF, 21);
    m_cfg = 1'b1;
    m_rst_cnt++;
    repeat (3 * BIT) @(posedge clk);
    check("rst_pulses", n_rst_seen, m_rst_cnt);
    check("configured", {31'd0, configured}, 32'd1);

    // Directed queries
    query(1'b0);
    offer(1'b0, 16'h1234);
    check_ready();
    query(1'b0);
    offer(1'b1, 16'hABCD);
    query(1'b0);
    query(1'b1);

    // Garbage frame and bad reset tail, then a normal query
    bad_frame(21'h0000AA, 8);
    bad_frame(21'h0087EF, 21);
    check("rst_pulses_after_bad", n_rst_seen, m_rst_cnt);
    offer(1'b0, 16'h00FF);
    query(1'b0);

    // Random mix
    for (int t = 0; t < 14; t++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: if (!m_kfull) offer(1'b0, 16'($urandom));
        1: if (!m_mfull) offer(1'b1, 16'($urandom));
        2, 3: query(1'b0);
        4: query(1'b1);
        default: begin
          g = 8'($urandom_range(0, 255));
          if (g == 8'h10 || g == 8'h11 || g == 8'hEF) g = 8'h55;
          bad_frame({13'd0, g}, 8);
        end
      endcase
    end

    // Reset in the middle of a data response with a new key pending
    if (!m_kfull) offer(1'b0, 16'h5A5A);
    exp_q.push_back(exp_frame(m_kfull, m_kdata));
    m_kfull = 1'b0;
    send_bits(21'h10, 8);
    for (int k = 0; k < 10 * BIT && to_host !== 1'b0; k++) @(negedge clk);
    check("mid_start_seen", {31'd0, to_host}, 32'd0);
    repeat (5 * BIT) @(negedge clk);
    offer(1'b0, 16'h0F0F);
    check_ready();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_to_host", {31'd0, to_host}, 32'd1);
    check("mid_rst_key_ready", {31'd0, bus.key_ready}, 32'd1);
    check("mid_rst_configured", {31'd0, configured}, 32'd0);
    exp_q.delete();
    m_cfg = 0; m_kfull = 0; m_mfull = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Unconfigured again: query stays unanswered
    query(1'b0);
    repeat (12 * BIT) @(posedge clk);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_err_pulses", n_err_seen, m_err_cnt);
    check("final_rst_pulses", n_rst_seen, m_rst_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/next_kbd_responder.md
Name: next_kbd_responder

Overview:
- Device end of the NeXT keyboard serial link; emulates the keyboard/mouse unit seen by the monitor-side host interface.
- Decodes host reset and query frames on from_host.
- Answers each query on to_host with a 21-bit ready frame or a 21-bit data frame.
- Sources key and mouse events through one-deep valid/ready holding registers; used for bench loopback and for standalone host-side bring-up.

Parameters:
- BIT_CLKS, 264: clk cycles per bit (53 us at monitor clock).
- HALF_BIT, 131: delay from start-bit falling edge to first sample point.
- RESP_GAP_BITS, 3: idle bit times between end of query and response start bit.

Ports:
- clk  in  1  monitor clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- from_host  in  1  host-to-device serial line; idle high.
- to_host  out  1  device-to-host serial line; idle high.
- key_valid  in  1  key event offered.
- key_data  in  16  key event: [7:0] low byte, [15:8] high byte.
- key_ready  out  1  key holding register empty.
- mouse_valid  in  1  mouse event offered.
- mouse_data  in  16  mouse event, same byte layout as key_data.
- mouse_ready  out  1  mouse holding register empty.
- configured  out  1  set by a valid reset frame.
- host_reset_seen  out  1  one-cycle pulse on a valid reset frame.
- frame_error  out  1  one-cycle pulse on an unrecognised host frame.

Behaviour:
- Reset (async, reset_n=0): to_host=1, key_ready=1, mouse_ready=1, configured=0, host_reset_seen=0, frame_error=0, FSM=IDLE, holding registers empty.
- Holding registers: each is loaded when valid&&ready, and ready drops the next cycle.
- A register empties on the first cycle of the response start bit that uses it.
- If a load and an empty coincide, the empty applies first and the load is captured; ready stays 0.
- from_host is passed through a 2-flop synchroniser; all sampling uses the synchronised value.
- FSM states: IDLE, RX_START, RX_BITS, GAP, TX_START, TX_BITS, RECOVER.
- IDLE -> RX_START on a synced falling edge.
- RX_START: wait HALF_BIT cycles. If the line is high there, it was a glitch -> IDLE. Otherwise -> RX_BITS.
- RX_BITS: sample every BIT_CLKS cycles, first bit received into h[0]. After 8 bits, decode:
  - h = 0,0,0,0,1,0,0,0: keyboard query -> GAP.
  - h = 1,0,0,0,1,0,0,0: mouse query -> GAP.
  - h = 1,1,1,1,0,1,1,1: collect 13 more bits. If the full 21 = 111101111110000000000, pulse host_reset_seen and set configured. No response is sent. -> RECOVER.
  - Anything else, or a bad reset tail: pulse frame_error -> RECOVER.
- Queries received while configured=0 are decoded, not answered, and go to RECOVER.
- RECOVER: wait until from_host has been high for one full BIT_CLKS -> IDLE.
- GAP: count RESP_GAP_BITS*BIT_CLKS cycles, then -> TX_START. A from_host falling edge during GAP abandons the response, leaves registers intact, and goes to RX_START.
- Response frame F[20:0]: selected by query type and that register's state. The start bit (0) is sent first, then F[0]..F[20], each BIT_CLKS cycles; to_host returns to 1 after F[20].
  - Ready frame: F[10]=1, F[9]=1, F[20]=1, all other bits 0.
  - Data frame: F[0]=0, F[8:1]=data[7:0], F[9]=0, F[10]=1, F[11]=0, F[19:12]=data[15:8], F[20]=0.
- Total response length: 22*BIT_CLKS cycles. from_host is ignored during TX_START/TX_BITS. After TX -> RECOVER.
- Keyboard queries use only the key register; mouse queries use only the mouse register.
- Reset asserted mid-frame aborts immediately: to_host=1 and pending data is discarded.
- Counters: bit-time counter 9 bits, bit index 5 bits, both wrap-free. The gap counter is sized for RESP_GAP_BITS*BIT_CLKS.

Test Plan:
- Drive the reset frame 111101111110000000000 (start bit + 21 bits, 264 clk/bit) -> one host_reset_seen pulse, configured=1, to_host stays 1.
- Send a keyboard query with the key register empty -> start bit on to_host 3*264 cycles after the last query bit, then ready frame F=0x100600 LSB first.
- Load key_data=0x1234, then send a keyboard query -> key_ready=0 until the response start bit. Host-side capture gives F[8:1]=0x34, F[19:12]=0x12, F[10]=1, F[20]=0.
- Load mouse_data=0xABCD, then send a keyboard query -> ready frame, mouse_ready stays 0. A following mouse query -> data frame carrying 0xABCD.
- Send a keyboard query before any reset -> no to_host activity. Send a garbage frame 0,1,0,1,0,1,0,1 -> frame_error pulse; the next valid query is answered normally.
- Assert reset_n=0 midway through a data response -> to_host=1 in the same cycle, key_ready=1, configured=0.
